// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state types for the ALU logic path.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RES_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_NOT = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seq_state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise unit; result occupies the low DATA_W bits of z.
module logic_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RES_W  = RES_W_DEF
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [1:0]        s,
    output logic [RES_W-1:0]  z
);

    always_comb begin
        z = '0;
        case (op_e'(s))
            OP_AND:  z[DATA_W-1:0] = x & y;
            OP_OR:   z[DATA_W-1:0] = x | y;
            OP_NOT:  z[DATA_W-1:0] = ~x;
            OP_XOR:  z[DATA_W-1:0] = x ^ y;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_sequencer.sv
// Registers operand transactions, feeds logic_unit, captures its result and
// presents it on a valid/ready output with a completed-operation counter.
module alu_logic_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RES_W  = RES_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [1:0]        in_op,
    output logic [DATA_W-1:0] lu_x,
    output logic [DATA_W-1:0] lu_y,
    output logic [1:0]        lu_s,
    input  logic [RES_W-1:0]  lu_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_z,
    output logic              out_zero,
    output logic [1:0]        out_op,
    output logic [CNT_W-1:0]  op_count
);

    seq_state_e state;
    // Holds in_ready low while in reset and until the first edge after release.
    logic       armed;

    assign out_valid = (state == RESP);
    assign in_ready  = armed && ((state == IDLE) || ((state == RESP) && out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            armed    <= 1'b0;
            lu_x     <= '0;
            lu_y     <= '0;
            lu_s     <= '0;
            out_z    <= '0;
            out_zero <= 1'b1;
            out_op   <= '0;
            op_count <= '0;
        end else if (clr) begin
            state    <= IDLE;
            armed    <= 1'b1;
            lu_x     <= '0;
            lu_y     <= '0;
            lu_s     <= '0;
            out_z    <= '0;
            out_zero <= 1'b1;
            out_op   <= '0;
            op_count <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && armed) begin
                        lu_x  <= in_x;
                        lu_y  <= in_y;
                        lu_s  <= in_op;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_z    <= lu_z;
                    out_zero <= (lu_z == '0);
                    out_op   <= lu_s;
                    state    <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        op_count <= op_count + 1'b1;
                        if (in_valid) begin
                            lu_x  <= in_x;
                            lu_y  <= in_y;
                            lu_s  <= in_op;
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Bench for alu_logic_sequencer with the real logic_unit; a second instance
// with a 2-bit counter exercises counter wrap on the same stimulus.
module tb_alu_logic_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [1:0]  in_op = '0;

    logic        in_ready, out_valid, out_zero;
    logic [7:0]  lu_x, lu_y;
    logic [1:0]  lu_s, out_op;
    logic [15:0] lu_z, out_z;
    logic [7:0]  op_count;

    logic        in_ready_w, out_valid_w, out_zero_w;
    logic [7:0]  lu_x_w, lu_y_w;
    logic [1:0]  lu_s_w, out_op_w;
    logic [15:0] lu_z_w, out_z_w;
    logic [1:0]  op_count_w;

    int errors = 0;
    int checks = 0;
    int unsigned done_ops = 0;

    always #5 clk = ~clk;

    alu_logic_sequencer #(.DATA_W(8), .RES_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_op(in_op),
        .lu_x(lu_x), .lu_y(lu_y), .lu_s(lu_s), .lu_z(lu_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_zero(out_zero), .out_op(out_op),
        .op_count(op_count)
    );

    logic_unit #(.DATA_W(8), .RES_W(16)) lu (
        .x(lu_x), .y(lu_y), .s(lu_s), .z(lu_z)
    );

    alu_logic_sequencer #(.DATA_W(8), .RES_W(16), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .in_x(in_x), .in_y(in_y), .in_op(in_op),
        .lu_x(lu_x_w), .lu_y(lu_y_w), .lu_s(lu_s_w), .lu_z(lu_z_w),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_z(out_z_w), .out_zero(out_zero_w), .out_op(out_op_w),
        .op_count(op_count_w)
    );

    logic_unit #(.DATA_W(8), .RES_W(16)) lu_w (
        .x(lu_x_w), .y(lu_y_w), .s(lu_s_w), .z(lu_z_w)
    );

    function automatic logic [15:0] ref_result(input logic [7:0] x, input logic [7:0] y,
                                               input logic [1:0] op);
        logic [7:0] r;
        case (op)
            2'd0:    r = x & y;
            2'd1:    r = x | y;
            2'd2:    r = ~x;
            default: r = x ^ y;
        endcase
        return {8'h00, r};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts;
        check("op_count", 32'(op_count), 32'(done_ops % 256));
        check("op_count_wrap", 32'(op_count_w), 32'(done_ops % 4));
    endtask

    // Presents a transaction and returns one step after acceptance (DUT in EXEC).
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
        int n = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_op = op;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        step;
        in_valid = 1'b0;
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_lu_x", 32'(lu_x), 32'(x));
    endtask

    // From EXEC: checks the result, stalls, then completes the handshake.
    task automatic finish(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op,
                          input int stall);
        logic [15:0] exp_z;
        exp_z = ref_result(x, y, op);
        step;
        check("resp_valid", 32'(out_valid), 32'd1);
        check("out_z", 32'(out_z), 32'(exp_z));
        check("out_zero", 32'(out_zero), 32'(exp_z == 16'h0));
        check("out_op", 32'(out_op), 32'(op));
        check("out_z_wrap", 32'(out_z_w), 32'(exp_z));
        for (int i = 0; i < stall; i++) begin
            step;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_out_z", 32'(out_z), 32'(exp_z));
            check_counts;
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        done_ops++;
        check("after_hs_valid", 32'(out_valid), 32'd0);
        check_counts;
    endtask

    initial begin
        logic [7:0] rx, ry;
        logic [1:0] rop;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_lu_x", 32'(lu_x), 32'd0);
        check_counts;
        rst_n = 1'b1;
        step;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_zero", 32'(out_zero), 32'd1);
        check_counts;

        // Four opcodes on CC/AA
        for (int op = 0; op < 4; op++) begin
            issue(8'hCC, 8'hAA, 2'(op));
            finish(8'hCC, 8'hAA, 2'(op), 0);
        end
        check("four_ops_count", 32'(op_count), 32'd4);

        // Zero flag
        issue(8'hFF, 8'hFF, 2'b11);
        finish(8'hFF, 8'hFF, 2'b11, 0);
        issue(8'h00, 8'h00, 2'b10);
        finish(8'h00, 8'h00, 2'b10, 0);

        // Backpressure with a pending transaction, then back-to-back accept
        issue(8'hCC, 8'hAA, 2'b01);
        step;
        in_valid = 1'b1;
        in_x = 8'h11;
        in_y = 8'h22;
        in_op = 2'b11;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_z", 32'(out_z), 32'h00EE);
            check("bp_out_op", 32'(out_op), 32'd1);
            check("bp_lu", 32'({lu_x, lu_y, 6'd0, lu_s}), 32'({8'hCC, 8'hAA, 8'h01}));
            check_counts;
            step;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step;
        out_ready = 1'b0;
        in_valid = 1'b0;
        done_ops++;
        check("b2b_exec_valid", 32'(out_valid), 32'd0);
        check("b2b_lu_x", 32'(lu_x), 32'h11);
        check_counts;
        finish(8'h11, 8'h22, 2'b11, 0);

        // Randomized traffic with random stalls
        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rop = 2'($urandom);
            issue(rx, ry, rop);
            finish(rx, ry, rop, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while in EXEC
        issue(8'h3C, 8'h0F, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        done_ops = 0;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_lu_x", 32'(lu_x), 32'd0);
        check("arst_out_zero", 32'(out_zero), 32'd1);
        check_counts;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step;
        check("arst_idle_in_ready", 32'(in_ready), 32'd1);
        check("arst_idle_valid", 32'(out_valid), 32'd0);

        // Synchronous clear while stalled in RESP
        issue(8'h5A, 8'hA5, 2'b11);
        step;
        check("clr_pre_valid", 32'(out_valid), 32'd1);
        clr = 1'b1;
        step;
        clr = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_out_z", 32'(out_z), 32'd0);
        check("clr_out_zero", 32'(out_zero), 32'd1);
        check("clr_lu_s", 32'(lu_s), 32'd0);
        check_counts;

        issue(8'h0F, 8'hF0, 2'b01);
        finish(8'h0F, 8'hF0, 2'b01, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
